// File: rtl/delay_chain_tdc.sv
// delay_chain_tdc - repeated launch/capture depth measurement across a chain of inverting stages.
// Reports the summed thermometer depth over a run and flags non-monotonic (bubble) codes.

module singlepath_1 (
  input  logic i_a,
  input  logic i_en,
  input  logic i_hold,
  output logic o_y
);
  assign o_y = ~(i_a & i_en) | i_hold;
endmodule

module delay_chain_tdc #(
  parameter int STAGES        = 5,
  parameter int SETTLE_CYCLES = 2,
  parameter int TRIALS_W      = 16,
  parameter int COUNT_W       = $clog2(STAGES + 1),
  parameter int ACC_W         = TRIALS_W + COUNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TRIALS_W-1:0] trials,
  input  logic [STAGES-1:0]   capMask,
  output logic                busy,
  output logic                done,
  output logic [ACC_W-1:0]    resultSum,
  output logic [COUNT_W-1:0]  lastCount,
  output logic                bubbleErr
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, CAPTURE, EVAL, SETTLE, DONE} state_t;

  state_t                r_state, w_next;
  logic                  r_launch_lvl;
  logic [STAGES-1:0]     r_cap;
  logic [TRIALS_W-1:0]   r_trials;
  logic [TRIALS_W-1:0]   r_cnt;
  logic [SW-1:0]         r_settle;
  logic [ACC_W-1:0]      r_sum;
  logic [COUNT_W-1:0]    r_last;
  logic                  r_bubble;

  (* keep = "true" *) logic [STAGES-1:0] w_tap;
  logic [STAGES-1:0]     w_prop;
  logic [COUNT_W-1:0]    w_depth;
  logic                  w_bubble;
  logic                  w_seen_zero;
  logic [TRIALS_W-1:0]   w_cnt_inc;
  logic                  w_settle_last;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
        singlepath_1 u_stage (.i_a(r_launch_lvl), .i_en(1'b1), .i_hold(1'b0), .o_y(w_tap[k]));
      end else begin : g_rest
        singlepath_1 u_stage (.i_a(w_tap[k-1]), .i_en(1'b1), .i_hold(1'b0), .o_y(w_tap[k]));
      end
    end
  endgenerate

  // Even-indexed taps settle to ~L, odd-indexed taps to L.
  always_comb begin
    w_prop      = '0;
    w_depth     = '0;
    w_bubble    = 1'b0;
    w_seen_zero = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      w_prop[i] = ~(r_cap[i] ^ capMask[i] ^ r_launch_lvl ^ ((i % 2) == 0));
      if (!w_prop[i]) begin
        w_seen_zero = 1'b1;
      end else if (w_seen_zero) begin
        w_bubble = 1'b1;
      end else begin
        w_depth = w_depth + COUNT_W'(1);
      end
    end
  end

  assign w_cnt_inc     = r_cnt + TRIALS_W'(1);
  assign w_settle_last = (r_settle == SW'(SETTLE_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (trials == '0) ? DONE : LAUNCH;
      LAUNCH:  w_next = CAPTURE;
      CAPTURE: w_next = EVAL;
      EVAL: begin
        if (SETTLE_CYCLES > 0)        w_next = SETTLE;
        else if (w_cnt_inc == r_trials) w_next = DONE;
        else                          w_next = LAUNCH;
      end
      SETTLE:  if (w_settle_last) w_next = (r_cnt == r_trials) ? DONE : LAUNCH;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_launch_lvl <= 1'b0;
      r_cap        <= '0;
      r_trials     <= '0;
      r_cnt        <= '0;
      r_settle     <= '0;
      r_sum        <= '0;
      r_last       <= '0;
      r_bubble     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_trials <= trials;
          r_cnt    <= '0;
          r_sum    <= '0;
          r_last   <= '0;
          r_bubble <= 1'b0;
        end
        LAUNCH:  r_launch_lvl <= ~r_launch_lvl;
        CAPTURE: r_cap <= w_tap;
        EVAL: begin
          r_last   <= w_depth;
          r_sum    <= r_sum + ACC_W'(w_depth);
          r_bubble <= r_bubble | w_bubble;
          r_cnt    <= w_cnt_inc;
          r_settle <= '0;
        end
        SETTLE:  r_settle <= r_settle + SW'(1);
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign resultSum = r_sum;
  assign lastCount = r_last;
  assign bubbleErr = r_bubble;
endmodule

// File: tb/tb_delay_chain_tdc.sv
// tb_delay_chain_tdc - scoreboard bench for delay_chain_tdc with a zero-delay chain.
// Expected depth/bubble are derived arithmetically from capMask.

module tb_delay_chain_tdc;
  localparam int STAGES  = 5;
  localparam int SETTLE  = 2;
  localparam int TW      = 16;
  localparam int CW      = 3;
  localparam int AW      = TW + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TW-1:0] trials;
  logic [4:0]    cap_mask;
  logic          busy;
  logic          done;
  logic [AW-1:0] result_sum;
  logic [CW-1:0] last_count;
  logic          bubble_err;

  delay_chain_tdc #(.STAGES(STAGES), .SETTLE_CYCLES(SETTLE), .TRIALS_W(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .trials(trials), .capMask(cap_mask),
    .busy(busy), .done(done), .resultSum(result_sum), .lastCount(last_count),
    .bubbleErr(bubble_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          done_cyc;
    logic [31:0] sum;
    logic [31:0] last;
    logic [31:0] bub;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic lvl_model = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Depth is the position of the lowest masked tap; a bubble exists when any
  // tap above that position is unmasked (propagating) again.
  task automatic ref_model(input logic [4:0] m, output int d, output bit b);
    int mi;
    mi = int'(m);
    d  = 5;
    for (int i = 4; i >= 0; i--) if ((mi >> i) & 1) d = i;
    b  = (d < 5) && ((mi | ((1 << d) - 1)) != 31);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_done: got done=1 expected no pending run (cyc=%0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        check("resultSum", 32'(result_sum), e.sum);
        check("lastCount", 32'(last_count), e.last);
        check("bubbleErr", 32'(bubble_err), e.bub);
      end
    end
  end

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || sb.size() != 0) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle", busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input int t, input logic [4:0] m);
    exp_t e;
    int   d;
    bit   b;
    wait_idle();
    ref_model(m, d, b);
    trials     = TW'(t);
    cap_mask   = m;
    start      = 1'b1;
    e.done_cyc = cyc + 1 + t * (3 + SETTLE);
    e.sum      = 32'(t * d);
    e.last     = (t > 0) ? 32'(d) : 32'd0;
    e.bub      = (t > 0 && b) ? 32'd1 : 32'd0;
    sb.push_back(e);
    lvl_model  = lvl_model ^ logic'(t & 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b1;
    trials   = 16'd4;
    cap_mask = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sum", 32'(result_sum), 0);
    check("rst_bubble", 32'(bubble_err), 0);
    check("rst_last", 32'(last_count), 0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("no_start_in_reset", 32'(busy), 0);

    issue(4, 5'b00000);
    wait_idle();
    check("launch_lvl_after_4", 32'(dut.r_launch_lvl), 0);

    issue(0, 5'b00000);
    check("t0_busy_dc", 32'(busy), 1);
    @(negedge clk);
    check("t0_busy_after", 32'(busy), 0);

    issue(3, 5'b00100);
    issue(2, 5'b11000);

    issue(3, 5'b00000);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    trials = 16'd7;
    @(negedge clk);
    start  = 1'b0;
    trials = 16'd1;
    wait_idle();

    issue(4, 5'b00000);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    lvl_model = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_sum", 32'(result_sum), 0);
    check("abort_last", 32'(last_count), 0);
    check("abort_bubble", 32'(bubble_err), 0);
    check("abort_lvl", 32'(dut.r_launch_lvl), 0);
    repeat (40) @(negedge clk);

    for (int r = 0; r < 24; r++) begin
      logic [4:0] m;
      m = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
      issue(int'($urandom_range(0, 6)), m);
      wait_idle();
      check("launch_lvl_parity", 32'(dut.r_launch_lvl), 32'(lvl_model));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/delay_chain_tdc.md
Name: delay_chain_tdc

Overview:
- Parametrised, self-timed measurement wrapper around a chain of STAGES inverting singlepath_1 stages (keep-attributed inter-stage wires).
- A launch register toggles the chain input and a capture register samples every tap one clock later. The resulting thermometer code gives the propagation depth reached in one clock period.
- Repeats for a programmed number of trials, accumulates depth and flags non-monotonic (bubble) codes.
- Sits beside the fixed 5-stage chains as the generic hardware-delay sensor.

Parameters:
- STAGES, 5, number of chained singlepath_1 stages (>=1). Each stage is instantiated with control inputs 1'b1, 1'b0.
- SETTLE_CYCLES, 2, idle cycles after each capture before the next launch (0 allowed).
- TRIALS_W, 16, width of the trial count.
- COUNT_W, $clog2(STAGES+1), width of the per-trial depth.
- ACC_W, TRIALS_W+COUNT_W, accumulator width; cannot overflow.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run. Sampled only in IDLE.
- trials  in  TRIALS_W  trials per run. Latched when start is accepted.
- capMask  in  STAGES  test hook XORed into the captured taps. Tie to 0 in product use.
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a run ends
- resultSum  out  ACC_W  sum of per-trial depths for the last run
- lastCount  out  COUNT_W  depth of the most recent trial
- bubbleErr  out  1  sticky for the run. Set if any trial's code was non-monotonic.

Behaviour:
- Single clock domain. Reset: all outputs 0, launchLvl=0, capture register 0, trial counter 0, state IDLE.
- Reset mid-run aborts immediately. No done pulse is issued.
- Chain: stage 0 input = launchLvl. tap[k] = output of stage k, k=0..STAGES-1. The chain is purely combinational between launchLvl and the capture register.
- Normalisation: stage k inverts, so its settled value after launch level L is L^((k+1)&1).
  - prop[k] = ~(cap[k] ^ capMask[k] ^ L ^ ((k+1)&1)).
  - prop[k]=1 means the edge reached tap k.
- Depth: number of leading ones of prop starting at bit 0 (0..STAGES).
- Bubble: any prop[j]=1 after the first prop[i]=0 (j>i).
- FSM states: IDLE, LAUNCH, CAPTURE, EVAL, SETTLE, DONE.
  - IDLE: on start=1, latch trials; clear resultSum, lastCount, bubbleErr and the trial counter. Go to DONE if trials==0, else to LAUNCH.
  - LAUNCH (1 cycle): launchLvl <= ~launchLvl. Every trial is therefore a transition, alternating rising/falling.
  - CAPTURE (1 cycle): cap <= tap. The capture edge is exactly one clk period after the launch edge.
  - EVAL (1 cycle): lastCount <= depth; resultSum += depth; bubbleErr |= bubble; trial counter +1.
  - SETTLE: SETTLE_CYCLES cycles (skipped if 0). Then go to DONE if counter==latched trials, else to LAUNCH.
  - DONE (1 cycle): done=1, then IDLE.
- Timing: per-trial cost = 3+SETTLE_CYCLES cycles. With start accepted at edge e0, done is high in cycle 1+T*(3+SETTLE_CYCLES) after e0.
- start while busy is ignored. A trials change mid-run has no effect.
- resultSum, lastCount and bubbleErr hold their values after done until the next accepted start.
- launchLvl is not reset by start; it is reset only by rst.

Test Plan:
- Reset held 3 cycles with start=1 -> busy=0, done=0, resultSum=0, bubbleErr=0. No run starts.
- STAGES=5, SETTLE=2, trials=4, capMask=0, zero-delay sim chain:
  - done pulses exactly 21 cycles after the start edge.
  - resultSum=20, lastCount=5, bubbleErr=0.
  - launchLvl ends at 0.
- trials=0 -> done pulses in the cycle after start, busy high for 1 cycle, resultSum=0.
- capMask=5'b00100, trials=3 -> each depth=2, resultSum=6, bubbleErr=1.
- capMask=5'b11000, trials=2 -> depth=3, resultSum=6, bubbleErr=0 (clean truncation, no bubble).
- Mid-run checks:
  - Assert rst in the 7th cycle of a 4-trial run -> all outputs 0 next cycle, no done pulse.
  - A second start pulsed mid-run -> ignored; the run completes normally.
